// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: decode control and redirects in, instruction memory handshake,
// and the instruction presented to the IF/ID register.
interface fetch_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        exc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, exc, mem_ack, mem_rdata,
    output mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );

  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, exc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc_plus4
  );
endinterface

// File: rtl/fetch_sequencer.sv
// MIPS program counter and instruction fetch sequencer: one outstanding req/ack fetch,
// one-entry output to decode, redirects buffered while a fetch is in flight.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OUT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic        pend_exc_q, pend_exc_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;

  logic        redir_now;
  logic        take_new;
  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;

  always_comb begin
    redir_now = bus.exc | bus.jmp | bus.br_taken;
    if (bus.exc) begin
      redir_raw = EXC_VEC;
    end else if (bus.jmp) begin
      redir_raw = bus.jmp_target;
    end else begin
      redir_raw = bus.br_target;
    end
    redir_tgt = {redir_raw[31:2], 2'b00};
    // A buffered exception is only displaced by another exception.
    take_new  = redir_now & ~(pend_v_q & pend_exc_q & ~bus.exc);
    pc_plus4  = pc_q + 32'd4;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_v_d      = pend_v_q;
    pend_exc_d    = pend_exc_q;
    pend_addr_d   = pend_addr_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (bus.mem_ack) begin
          if (pend_v_q || redir_now) begin
            pc_d       = take_new ? redir_tgt : pend_addr_q;
            pend_v_d   = 1'b0;
            pend_exc_d = 1'b0;
          end else begin
            if_instr_d    = bus.mem_rdata;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            if_valid_d    = 1'b1;
            pc_d          = pc_plus4;
            state_d       = OUT;
          end
        end else if (take_new) begin
          pend_addr_d = redir_tgt;
          pend_exc_d  = bus.exc;
          pend_v_d    = 1'b1;
        end
      end

      OUT: begin
        if (redir_now) begin
          if_valid_d = 1'b0;
          pc_d       = redir_tgt;
          state_d    = FETCH;
        end else if (!bus.stall) begin
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VEC;
      pend_v_q      <= 1'b0;
      pend_exc_q    <= 1'b0;
      pend_addr_q   <= '0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_v_q      <= pend_v_d;
      pend_exc_q    <= pend_exc_d;
      pend_addr_q   <= pend_addr_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  assign bus.mem_req     = (state_q == FETCH);
  assign bus.mem_addr    = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc_plus4 = if_pc_plus4_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural fetch model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] EXV = 32'h8000_0180;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_VEC (RV),
    .EXC_VEC   (EXV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a request is outstanding (m_req) or an instruction is held (m_out_v),
  // or we are in the single warm-up cycle after reset (m_boot).
  bit          m_boot, m_req, m_out_v;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_pend_addr;
  int          m_pend_rank;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int          new_rank;
    logic [31:0] new_tgt;
    if (reset) begin
      m_boot = 1; m_req = 0; m_out_v = 0; m_pc = RV; m_pend_rank = 0;
      m_instr = '0; m_ipc = '0; m_ipc4 = '0;
      return;
    end
    new_rank = bus.exc ? 2 : ((bus.jmp || bus.br_taken) ? 1 : 0);
    new_tgt  = bus.exc ? EXV : (bus.jmp ? bus.jmp_target : bus.br_target);
    new_tgt  = new_tgt & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_boot = 0;
      m_req  = 1;
    end else if (m_req) begin
      if (new_rank != 0 && new_rank >= m_pend_rank) begin
        m_pend_rank = new_rank;
        m_pend_addr = new_tgt;
      end
      if (bus.mem_ack) begin
        if (m_pend_rank != 0) begin
          m_pc = m_pend_addr;
          m_pend_rank = 0;
        end else begin
          m_instr = bus.mem_rdata;
          m_ipc   = m_pc;
          m_ipc4  = m_pc + 32'd4;
          m_pc    = m_pc + 32'd4;
          m_req   = 0;
          m_out_v = 1;
        end
      end
    end else if (m_out_v) begin
      if (new_rank != 0) begin
        m_out_v = 0; m_pc = new_tgt; m_req = 1;
      end else if (!bus.stall) begin
        m_out_v = 0; m_req = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_req",     {31'b0, bus.mem_req},  {31'b0, m_req});
    chk("mem_addr",    bus.mem_addr,          m_pc);
    chk("if_valid",    {31'b0, bus.if_valid}, {31'b0, m_out_v});
    chk("if_instr",    bus.if_instr,          m_instr);
    chk("if_pc",       bus.if_pc,             m_ipc);
    chk("if_pc_plus4", bus.if_pc_plus4,       m_ipc4);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    bus.br_taken = 1'b0;
    bus.jmp      = 1'b0;
    bus.exc      = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  // One request acked a cycle after it appears; decode then holds the result.
  task automatic fetch_one(input logic [31:0] addr);
    chk("lit_req_on",  {31'b0, bus.mem_req}, 32'd1);
    chk("lit_addr",    bus.mem_addr, addr);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = mem_word(addr);
    step();
    chk("lit_valid",   {31'b0, bus.if_valid}, 32'd1);
    chk("lit_pc",      bus.if_pc, addr);
    chk("lit_pc4",     bus.if_pc_plus4, addr + 32'd4);
    chk("lit_instr",   bus.if_instr, mem_word(addr));
    chk("lit_req_off", {31'b0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.jmp = 1'b0; bus.jmp_target = '0; bus.exc = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    m_boot = 1; m_req = 0; m_out_v = 0; m_pc = RV; m_pend_rank = 0;
    m_instr = '0; m_ipc = '0; m_ipc4 = '0; m_pend_addr = '0;

    // Reset state
    step();
    step();
    chk("rst_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_pc",    bus.if_pc, 32'h0);
    chk("rst_pc4",   bus.if_pc_plus4, 32'h0);
    reset = 1'b0;
    step();

    // Sequential fetch 0x0, 0x4
    fetch_one(32'h0);
    step();
    fetch_one(32'h4);

    // Stall holds the instruction with no request
    bus.stall = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("stall_pc",    bus.if_pc, 32'h4);
      chk("stall_instr", bus.if_instr, mem_word(32'h4));
      chk("stall_req",   {31'b0, bus.mem_req}, 32'd0);
    end
    bus.stall = 1'b0;
    step();
    chk("seq_addr8", bus.mem_addr, 32'h8);

    // Branch mid-fetch: fetch of 0x8 is dropped
    bus.br_taken = 1'b1; bus.br_target = 32'h100;
    step();
    step();
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = mem_word(32'h8);
    step();
    chk("br_novalid", {31'b0, bus.if_valid}, 32'd0);
    fetch_one(32'h100);
    step();

    // Simultaneous exc/jmp/br, then a later jmp that must not override
    bus.exc = 1'b1; bus.jmp = 1'b1; bus.jmp_target = 32'h200;
    bus.br_taken = 1'b1; bus.br_target = 32'h300;
    step();
    bus.jmp = 1'b1; bus.jmp_target = 32'h400;
    step();
    bus.mem_ack = 1'b1; bus.mem_rdata = mem_word(32'h104);
    step();
    chk("exc_addr",  bus.mem_addr, 32'h8000_0180);
    chk("exc_valid", {31'b0, bus.if_valid}, 32'd0);

    // PC wrap at the top of the address space
    bus.jmp = 1'b1; bus.jmp_target = 32'hFFFF_FFFC; bus.mem_ack = 1'b1;
    step();
    fetch_one(32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_pc_plus4, 32'h0);
    step();
    chk("wrap_addr", bus.mem_addr, 32'h0);

    // Unaligned jump target
    bus.jmp = 1'b1; bus.jmp_target = 32'h203;
    step();
    chk("align_hold", bus.mem_addr, 32'h0);
    bus.mem_ack = 1'b1; bus.mem_rdata = mem_word(32'h0);
    step();
    chk("align_addr", bus.mem_addr, 32'h200);

    // Reset while a request is outstanding; the late ack lands in the warm-up cycle
    reset = 1'b1;
    step();
    chk("rmid_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("rmid_valid", {31'b0, bus.if_valid}, 32'd0);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    step();
    chk("rmid_restart", bus.mem_addr, RV);
    chk("rmid_reqon",   {31'b0, bus.mem_req}, 32'd1);

    // Random traffic
    for (int unsigned n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 299) == 0);
      bus.stall = ($urandom_range(0, 2) == 0);
      if (m_req) begin
        bus.mem_ack   = ($urandom_range(0, 2) == 0);
        bus.mem_rdata = mem_word(m_pc);
      end else begin
        bus.mem_ack   = ($urandom_range(0, 7) == 0);
        bus.mem_rdata = $urandom;
      end
      if (!m_boot) begin
        bus.exc      = ($urandom_range(0, 19) == 0);
        bus.jmp      = ($urandom_range(0, 9) == 0);
        bus.br_taken = ($urandom_range(0, 9) == 0);
      end
      bus.jmp_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      bus.br_target  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
